// File: rtl/bus_turnaround_ctrl.sv
// Direction/enable sequencer for a 74HCT245 data-bus transceiver with dead-cycle turnaround.
// Define BUS_TURN_B2B_EN to allow a new request to be accepted at the RELEASE edge.
module bus_turnaround_ctrl #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned TURN_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             req_rd,
  output logic             busy,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             xcvr_dir,
  output logic             xcvr_nOE,
  output logic [WIDTH-1:0] a_out,
  output logic             a_oe,
  input  logic [WIDTH-1:0] a_in
);

  localparam logic [3:0] TurnLoad = 4'(TURN_CYCLES);
  localparam logic [3:0] HoldLoad = 4'(HOLD_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StTurn,
    StDrive,
    StSample,
    StRelease
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             noe_q, noe_d;
  logic             a_oe_q, a_oe_d;
  logic             busy_q, busy_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] a_out_q, a_out_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             accept_ok;
  logic             new_dir;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    a_out_d    = a_out_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    new_dir    = req_wr;

`ifdef BUS_TURN_B2B_EN
    accept_ok = (state_q == StIdle) || (state_q == StRelease);
`else
    accept_ok = (state_q == StIdle);
`endif

    unique case (state_q)
      StTurn: begin
        // xcvr_dir already holds the new direction, so it selects the transfer phase.
        if (cnt_q == 4'd1) begin
          state_d = dir_q ? StDrive : StSample;
          cnt_d   = HoldLoad;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDrive: begin
        if (cnt_q == 4'd1) begin
          state_d = StRelease;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StSample: begin
        if (cnt_q == 4'd1) begin
          state_d    = StRelease;
          rd_data_d  = a_in;
          rd_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    // Write has priority; a simultaneous read is dropped.
    if (accept_ok && (req_wr || req_rd)) begin
      if (req_wr) begin
        a_out_d = wr_data;
      end
      if (new_dir != dir_q) begin
        state_d = StTurn;
        dir_d   = new_dir;
        cnt_d   = TurnLoad;
      end else begin
        state_d = new_dir ? StDrive : StSample;
        cnt_d   = HoldLoad;
      end
    end

    noe_d  = !((state_d == StDrive) || (state_d == StSample));
    a_oe_d = (state_d == StDrive);
`ifdef BUS_TURN_B2B_EN
    busy_d = (state_d == StTurn) || (state_d == StDrive) || (state_d == StSample);
`else
    busy_d = (state_d != StIdle);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      dir_q      <= 1'b0;
      noe_q      <= 1'b1;
      a_oe_q     <= 1'b0;
      busy_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      a_out_q    <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      noe_q      <= noe_d;
      a_oe_q     <= a_oe_d;
      busy_q     <= busy_d;
      rd_valid_q <= rd_valid_d;
      a_out_q    <= a_out_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign busy     = busy_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign xcvr_dir = dir_q;
  assign xcvr_nOE = noe_q;
  assign a_out    = a_out_q;
  assign a_oe     = a_oe_q;

endmodule
